fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined processor. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds decode and register-file read. It supports stalls from the hazard unit, branch/jump redirects from execute, and boot-PC loading under reset.

Parameters:
NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on bubble/flush/reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  pipeline clock, rising-edge
rst  in  1  synchronous, active-high reset
boot_pc  in  32  PC loaded while rst=1 (bits[1:0] ignored)
imem_addr  out  32  instruction-memory address, equals current PC (combinational from PC register)
imem_data  in  32  instruction word at imem_addr, combinational read, valid same cycle
stall  in  1  hold PC and IF/ID (from hazard unit)
redirect  in  1  taken branch/jump from execute
redirect_pc  in  32  target PC when redirect=1
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  fetched instruction
if_id_pc  out  32  address of if_id_instr
if_id_pc4  out  32  if_id_pc + PC_STEP
fetch_count  out  16  count of instructions loaded into IF/ID
misalign_err  out  1  sticky: a redirect target had nonzero bits[1:0]

Behaviour:
- All state updates on rising clk; no asynchronous paths except imem_addr = pc.
- Reset (rst=1 at edge): pc <= {boot_pc[31:2],2'b00}; if_id_valid 0; if_id_instr NOP_INSTR; if_id_pc 0; if_id_pc4 0; fetch_count 0; misalign_err 0. Reset overrides stall and redirect. Reset mid-operation discards in-flight IF/ID contents immediately at that edge.
- Priority when rst=0: redirect > stall > sequential.
- Redirect: pc <= {redirect_pc[31:2],2'b00}. IF/ID becomes a bubble: valid 0, instr NOP_INSTR, pc/pc4 unchanged. fetch_count unchanged. If redirect_pc[1:0]!=0, misalign_err <= 1, and it stays 1 until reset. Redirect with stall=1 still redirects and bubbles; stall is ignored that cycle.
- Stall (redirect=0): pc, all IF/ID outputs, and fetch_count hold. imem_addr stays stable. Multi-cycle stalls hold indefinitely.
- Sequential: pc <= pc + PC_STEP, 32-bit modulo (32'hFFFF_FFFC -> 32'h0000_0000, no flag). IF/ID <= {valid 1, imem_data, pc, pc+PC_STEP}. fetch_count <= fetch_count+1, 16-bit wrap (FFFF -> 0000).
- Latency: the instruction at address A appears on if_id_instr one edge after imem_addr=A, provided there is no stall or redirect on that edge.
- First cycle after reset deasserts: imem_addr=boot_pc and if_id_valid=0. The first valid IF/ID appears after the next edge.
- if_id_pc4 is always if_id_pc + PC_STEP whenever if_id_valid=1.
- No X propagation: every output has a defined value from the first reset edge.

Test Plan:
1. rst=1 for 2 cycles with boot_pc=0x0000_0008, then release -> imem_addr=0x8, if_id_valid=0, fetch_count=0, misalign_err=0.
2. Memory returns 0x0128_5022 at 0x8, 0x0000_0011 at 0xC, and 0x0000_0022 at 0x10; 3 free-running cycles -> IF/ID sequence (pc,instr,pc4) = (0x8,0x01285022,0xC), (0xC,0x11,0x10), (0x10,0x22,0x14); fetch_count=3; imem_addr=0x14.
3. stall=1 for 3 cycles after scenario 2 -> imem_addr stays 0x14, IF/ID stays (0x10,0x22), fetch_count=3. Release stall -> next edge loads pc 0x14.
4. redirect=1, stall=1, redirect_pc=0x40 on the same edge -> imem_addr=0x40, if_id_valid=0, if_id_instr=NOP_INSTR, fetch_count unchanged. Next free edge -> if_id_pc=0x40, valid=1.
5. redirect_pc=0x0000_0022 -> imem_addr=0x20 and misalign_err=1. misalign_err remains 1 through 10 normal cycles and clears only on rst.
6. Boot at 0xFFFF_FFFC, run 2 cycles -> if_id_pc=0xFFFF_FFFC with pc4=0x0000_0000, then if_id_pc=0x0. Assert rst mid-run -> all outputs return to reset values at that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, loads IF/ID.
// Redirect beats stall beats sequential fetch; reset beats all.
module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int unsigned PC_STEP   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] boot_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [15:0] fetch_count,
   output logic        misalign_err
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] pc_inc;
   if_id_t      if_id;
   if_id_t      if_id_next;
   logic [15:0] cnt;
   logic [15:0] cnt_next;
   logic        err;
   logic        err_next;

   assign pc_inc = pc + STEP;

   always_comb begin
      pc_next    = pc;
      if_id_next = if_id;
      cnt_next   = cnt;
      err_next   = err;
      priority case (1'b1)
         redirect: begin
            pc_next          = {redirect_pc[31:2], 2'b00};
            if_id_next.valid = 1'b0;
            if_id_next.instr = NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00)
               err_next = 1'b1;
         end
         stall: begin
         end
         default: begin
            pc_next          = pc_inc;
            if_id_next.valid = 1'b1;
            if_id_next.instr = imem_data;
            if_id_next.pc    = pc;
            if_id_next.pc4   = pc_inc;
            cnt_next         = cnt + 16'd1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= {boot_pc[31:2], 2'b00};
         if_id.valid <= 1'b0;
         if_id.instr <= NOP_INSTR;
         if_id.pc    <= 32'h0;
         if_id.pc4   <= 32'h0;
         cnt         <= 16'h0;
         err         <= 1'b0;
      end else begin
         pc    <= pc_next;
         if_id <= if_id_next;
         cnt   <= cnt_next;
         err   <= err_next;
      end
   end

   assign imem_addr    = pc;
   assign if_id_valid  = if_id.valid;
   assign if_id_instr  = if_id.instr;
   assign if_id_pc     = if_id.pc;
   assign if_id_pc4    = if_id.pc4;
   assign fetch_count  = cnt;
   assign misalign_err = err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
// Expected IF/ID bundles are queued at drive time, popped after the edge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] boot_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [15:0] fetch_count;
   logic        misalign_err;

   typedef struct packed {
      logic        v;
      logic [31:0] i;
      logic [31:0] p;
      logic [31:0] p4;
   } exp_t;

   exp_t        q[$];
   exp_t        held;
   logic [31:0] mpc;
   logic [15:0] mcnt;
   logic        merr;
   int          vectors = 0;
   int          errs = 0;

   fetch_stage #(.NOP_INSTR(NOP), .PC_STEP(4)) dut (
      .clk(clk), .rst(rst), .boot_pc(boot_pc),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
      .fetch_count(fetch_count), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h8:   return 32'h0128_5022;
         32'hC:   return 32'h0000_0011;
         32'h10:  return 32'h0000_0022;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   always_comb imem_data = mem(imem_addr);

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic st,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] bpc, input logic full);
      exp_t e;
      rst = r; stall = st; redirect = rd;
      redirect_pc = rpc; boot_pc = bpc;
      if (r) begin
         mpc  = {bpc[31:2], 2'b00};
         held = '{1'b0, NOP, 32'h0, 32'h0};
         mcnt = 16'h0;
         merr = 1'b0;
      end else if (rd) begin
         mpc     = {rpc[31:2], 2'b00};
         held.v  = 1'b0;
         held.i  = NOP;
         if (rpc[1:0] != 2'b00) merr = 1'b1;
      end else if (!st) begin
         held = '{1'b1, mem(mpc), mpc, mpc + 32'd4};
         mpc  = mpc + 32'd4;
         mcnt = mcnt + 16'd1;
      end
      q.push_back(held);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("imem_addr", imem_addr, mpc);
      chk("fetch_count", {16'h0, fetch_count}, {16'h0, mcnt});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, merr});
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.v});
      if (full) begin
         chk("if_id_instr", if_id_instr, e.i);
         chk("if_id_pc", if_id_pc, e.p);
         chk("if_id_pc4", if_id_pc4, e.p4);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++)
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      // 1: reset with boot 0x8 (low bits of a second boot value ignored)
      cyc(1'b1, 1'b1, 1'b1, 32'h3, 32'h0000_000B, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b1);
      chk("first_addr", imem_addr, 32'h8);
      // 2: three sequential fetches
      run(3);
      chk("seq_addr", imem_addr, 32'h14);
      chk("seq_pc", if_id_pc, 32'h10);
      chk("seq_instr", if_id_instr, 32'h22);
      // 3: three-cycle stall then release
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("stall_cnt", {16'h0, fetch_count}, 32'd3);
      run(1);
      chk("unstall_pc", if_id_pc, 32'h14);
      // 4: redirect wins over stall
      cyc(1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 1'b1);
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_nop", if_id_instr, NOP);
      run(1);
      chk("redir_load", if_id_pc, 32'h40);
      // 5: misaligned target, sticky flag
      cyc(1'b0, 1'b0, 1'b1, 32'h22, 32'h0, 1'b1);
      chk("mis_addr", imem_addr, 32'h20);
      run(10);
      cyc(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 1'b1);
      run(2);
      chk("mis_sticky", {31'h0, misalign_err}, 32'h1);
      // 6: PC wrap and mid-run reset
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1);
      run(1);
      chk("wrap_pc4", if_id_pc4, 32'h0);
      run(1);
      chk("wrap_pc", if_id_pc, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 1'b1);
      run(2);
      cyc(1'b1, 1'b0, 1'b1, 32'h44, 32'h0000_0200, 1'b1);
      chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst_err", {31'h0, misalign_err}, 32'h0);
      // fetch_count 16-bit wrap
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_1000, 1'b1);
      for (int k = 0; k < 65537; k++)
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("cnt_wrap", {16'h0, fetch_count}, 32'h1);
      run(2);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errs);
      $finish;
   end

endmodule
